// File: rtl/pattern_pkg.sv
// pattern_pkg: shared types, constants and helpers for the pattern-count engine.
//   state_t          - engine FSM states
//   MAX_WIN_PER_BYTE - window positions that can end inside one byte
//   hist_width()     - width of the cross-byte history register for a pattern width
//   sat_add()        - saturating add, clamped to a caller-supplied maximum
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_WIN_PER_BYTE = 8;

  // A 1-bit pattern needs no history, but a zero-width vector is illegal,
  // so the register is kept at one (unused) bit in that case.
  function automatic int hist_width(input int pat_w);
    return (pat_w > 1) ? pat_w - 1 : 1;
  endfunction

  // Operands are 32-bit so the helper serves any count width up to 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/byte_window_matcher.sv
// byte_window_matcher: combinational window comparison for one stream byte.
//   pat        in  PAT_W   pattern, MSB is the earliest bit
//   history    in  HIST_W  last PAT_W-1 bits of the preceding bytes (LSB newest)
//   byte_in    in  8       current byte, bit 7 earliest
//   hist_valid in  1       history holds real stream bits (false for byte 0)
//   inb_cnt    out 4       matches fully inside byte_in (0..9-PAT_W)
//   any_match  out 1       at least one in-byte match
//   cross_cnt  out 4       matches ending in byte_in, boundary-crossing allowed (0..8)
module byte_window_matcher
  import pattern_pkg::*;
#(
  parameter int PAT_W  = 5,
  parameter int HIST_W = hist_width(PAT_W)
) (
  input  logic [PAT_W-1:0]  pat,
  input  logic [HIST_W-1:0] history,
  input  logic [7:0]        byte_in,
  input  logic              hist_valid,
  output logic [3:0]        inb_cnt,
  output logic              any_match,
  output logic [3:0]        cross_cnt
);

  // History sits above the byte so that ext reads MSB-first in stream order.
  logic [HIST_W+7:0]             ext;
  logic [MAX_WIN_PER_BYTE-1:0]   inb_hit;
  logic [MAX_WIN_PER_BYTE-1:0]   cross_hit;

  assign ext = {history, byte_in};

  // Window gi ends at bit gi of the current byte. It is internal when it
  // does not reach above bit 7; otherwise it borrows history bits and only
  // counts once the history is real.
  for (genvar gi = 0; gi < MAX_WIN_PER_BYTE; gi++) begin : g_win
    if (gi + PAT_W <= 8) begin : g_internal
      assign inb_hit[gi]   = (byte_in[gi +: PAT_W] == pat);
      assign cross_hit[gi] = inb_hit[gi];
    end else begin : g_crossing
      assign inb_hit[gi]   = 1'b0;
      assign cross_hit[gi] = hist_valid && (ext[gi +: PAT_W] == pat);
    end
  end

  always_comb begin
    inb_cnt   = '0;
    cross_cnt = '0;
    for (int i = 0; i < MAX_WIN_PER_BYTE; i++) begin
      inb_cnt   = inb_cnt   + {3'b000, inb_hit[i]};
      cross_cnt = cross_cnt + {3'b000, cross_hit[i]};
    end
  end

  assign any_match = |inb_hit;

endmodule

// File: rtl/pattern_count_engine.sv
// pattern_count_engine: counts occurrences of a PAT_W-bit pattern in a
// NUM_BYTES-byte stream received MSB-first over a valid/ready byte port.
//   clk        in  1      clock, rising edge
//   reset      in  1      asynchronous active-low reset
//   start      in  1      begin a search (honoured in IDLE/DONE only)
//   pat        in  PAT_W  pattern, latched on an accepted start
//   byte_in    in  8      stream byte, bit 7 earliest
//   byte_valid in  1      byte_in valid
//   byte_ready out 1      engine accepts a byte (RUN only)
//   busy       out 1      search in progress
//   done       out 1      results valid, held until the next accepted start
//   cnt_inbyte out CNT_W  matches not crossing a byte boundary
//   cnt_bytes  out CNT_W  bytes holding at least one in-byte match
//   cnt_cross  out CNT_W  matches anywhere in the bit stream
module pattern_count_engine
  import pattern_pkg::*;
#(
  parameter int PAT_W     = 5,
  parameter int NUM_BYTES = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_inbyte,
  output logic [CNT_W-1:0] cnt_bytes,
  output logic [CNT_W-1:0] cnt_cross
);

  localparam int          HIST_W  = hist_width(PAT_W);
  localparam int          IDX_W   = 9;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t             state_reg, state_next;
  logic               start_accept;
  logic               xfer;
  logic               last_byte;

  logic [PAT_W-1:0]   pat_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [HIST_W-1:0]  history_reg;
  logic               hist_valid_reg;

  logic [3:0]         m_inb_cnt;
  logic               m_any;
  logic [3:0]         m_cross_cnt;

  logic               s1_valid_reg;
  logic [3:0]         s1_inb_reg;
  logic               s1_any_reg;
  logic [3:0]         s1_cross_reg;

  logic [CNT_W-1:0]   cnt_inbyte_reg;
  logic [CNT_W-1:0]   cnt_bytes_reg;
  logic [CNT_W-1:0]   cnt_cross_reg;

  assign last_byte = (idx_reg == IDX_W'(NUM_BYTES - 1));
  assign xfer      = byte_valid && byte_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    byte_ready   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    start_accept = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid && last_byte) state_next = DRAIN;
      end
      // One cycle for the last byte to move from stage 1 into the accumulators.
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          start_accept = 1'b1;
          state_next   = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------- matcher
  byte_window_matcher #(
    .PAT_W  (PAT_W),
    .HIST_W (HIST_W)
  ) u_matcher (
    .pat        (pat_reg),
    .history    (history_reg),
    .byte_in    (byte_in),
    .hist_valid (hist_valid_reg),
    .inb_cnt    (m_inb_cnt),
    .any_match  (m_any),
    .cross_cnt  (m_cross_cnt)
  );

  // ------------------------------------------- stage 1: per-byte results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_reg        <= '0;
      idx_reg        <= '0;
      history_reg    <= '0;
      hist_valid_reg <= 1'b0;
      s1_valid_reg   <= 1'b0;
      s1_inb_reg     <= '0;
      s1_any_reg     <= 1'b0;
      s1_cross_reg   <= '0;
    end else if (start_accept) begin
      pat_reg        <= pat;
      idx_reg        <= '0;
      history_reg    <= '0;
      hist_valid_reg <= 1'b0;
      s1_valid_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= xfer;
      if (xfer) begin
        idx_reg        <= idx_reg + 1'b1;
        // Newest PAT_W-1 stream bits are the low bits of this byte.
        history_reg    <= byte_in[HIST_W-1:0];
        hist_valid_reg <= 1'b1;
        s1_inb_reg     <= m_inb_cnt;
        s1_any_reg     <= m_any;
        s1_cross_reg   <= m_cross_cnt;
      end
    end
  end

  // ----------------------------------------- stage 2: saturating totals
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_inbyte_reg <= '0;
      cnt_bytes_reg  <= '0;
      cnt_cross_reg  <= '0;
    end else if (start_accept) begin
      cnt_inbyte_reg <= '0;
      cnt_bytes_reg  <= '0;
      cnt_cross_reg  <= '0;
    end else if (s1_valid_reg) begin
      cnt_inbyte_reg <= CNT_W'(sat_add(32'(cnt_inbyte_reg), 32'(s1_inb_reg), CNT_MAX));
      cnt_bytes_reg  <= CNT_W'(sat_add(32'(cnt_bytes_reg), 32'(s1_any_reg), CNT_MAX));
      cnt_cross_reg  <= CNT_W'(sat_add(32'(cnt_cross_reg), 32'(s1_cross_reg), CNT_MAX));
    end
  end

  assign cnt_inbyte = cnt_inbyte_reg;
  assign cnt_bytes  = cnt_bytes_reg;
  assign cnt_cross  = cnt_cross_reg;

endmodule

// File: tb/tb_pattern_count_engine.sv
module tb_pattern_count_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] pat5 = '0;
  logic [7:0] pat8 = '0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;
  logic       start_def = 1'b0, start_two = 1'b0, start_w8 = 1'b0, start_sat = 1'b0;

  logic        rdy_def, rdy_two, rdy_w8, rdy_sat;
  logic        bsy_def, bsy_two, bsy_w8, bsy_sat;
  logic        dn_def, dn_two, dn_w8, dn_sat;
  logic [15:0] ci_def, cb_def, cc_def, ci_two, cb_two, cc_two, ci_w8, cb_w8, cc_w8;
  logic [3:0]  ci_sat, cb_sat, cc_sat;

  int          sel = 0;
  logic        m_ready, m_busy, m_done;
  logic [15:0] m_ci, m_cb, m_cc;

  logic [7:0]  data [256];
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  pattern_count_engine u_def (
    .clk(clk), .reset(reset_n), .start(start_def), .pat(pat5), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy_def), .busy(bsy_def), .done(dn_def),
    .cnt_inbyte(ci_def), .cnt_bytes(cb_def), .cnt_cross(cc_def));

  pattern_count_engine #(.NUM_BYTES(2)) u_two (
    .clk(clk), .reset(reset_n), .start(start_two), .pat(pat5), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy_two), .busy(bsy_two), .done(dn_two),
    .cnt_inbyte(ci_two), .cnt_bytes(cb_two), .cnt_cross(cc_two));

  pattern_count_engine #(.PAT_W(8), .NUM_BYTES(4)) u_w8 (
    .clk(clk), .reset(reset_n), .start(start_w8), .pat(pat8), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy_w8), .busy(bsy_w8), .done(dn_w8),
    .cnt_inbyte(ci_w8), .cnt_bytes(cb_w8), .cnt_cross(cc_w8));

  pattern_count_engine #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset_n), .start(start_sat), .pat(pat5), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy_sat), .busy(bsy_sat), .done(dn_sat),
    .cnt_inbyte(ci_sat), .cnt_bytes(cb_sat), .cnt_cross(cc_sat));

  // Route the instance under test onto one set of observation signals.
  always_comb begin
    m_ready = rdy_def; m_busy = bsy_def; m_done = dn_def;
    m_ci = ci_def; m_cb = cb_def; m_cc = cc_def;
    case (sel)
      1: begin m_ready = rdy_two; m_busy = bsy_two; m_done = dn_two;
               m_ci = ci_two; m_cb = cb_two; m_cc = cc_two; end
      2: begin m_ready = rdy_w8; m_busy = bsy_w8; m_done = dn_w8;
               m_ci = ci_w8; m_cb = cb_w8; m_cc = cc_w8; end
      3: begin m_ready = rdy_sat; m_busy = bsy_sat; m_done = dn_sat;
               m_ci = 16'(ci_sat); m_cb = 16'(cb_sat); m_cc = 16'(cc_sat); end
      default: ;
    endcase
  end

  task automatic check_value(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Reference: lay the bytes out as a bit list in stream order and count
  // windows directly from the definitions.
  task automatic ref_model(input int pw, input int nb, input int patv, input int cmax,
                           output int ci, output int cb, output int cc);
    int bits[$];
    int mask;
    int v;
    bit hit;
    ci = 0; cb = 0; cc = 0;
    mask = (1 << pw) - 1;
    for (int b = 0; b < nb; b++) begin
      hit = 1'b0;
      for (int k = 0; k <= 8 - pw; k++)
        if (((int'(data[b]) >> k) & mask) == patv) begin ci++; hit = 1'b1; end
      if (hit) cb++;
      for (int t = 7; t >= 0; t--) bits.push_back(int'(data[b][t]));
    end
    for (int s = 0; s + pw <= bits.size(); s++) begin
      v = 0;
      for (int t = 0; t < pw; t++) v = (v << 1) | bits[s + t];
      if (v == patv) cc++;
    end
    if (ci > cmax) ci = cmax;
    if (cb > cmax) cb = cmax;
    if (cc > cmax) cc = cmax;
  endtask

  task automatic set_start(input bit v);
    start_def = v && (sel == 0);
    start_two = v && (sel == 1);
    start_w8  = v && (sel == 2);
    start_sat = v && (sel == 3);
  endtask

  // gap_mode: 0 back-to-back, 1 valid low every third cycle, 2 random gaps.
  // abort_at >= 0 pulls reset low after that many bytes have transferred.
  task automatic run(input string name, input int s, input int pw, input int nb,
                     input int patv, input int cmax, input int gap_mode,
                     input bit poke_start, input int abort_at);
    int  ei, eb, ec;
    int  i, cyc;
    bit  fire;
    sel = s;
    ref_model(pw, nb, patv, cmax, ei, eb, ec);
    @(negedge clk);
    pat5 = 5'(patv); pat8 = 8'(patv);
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    check_value({name, " busy_after_start"}, m_busy, 1);
    check_value({name, " done_after_start"}, m_done, 0);
    check_value({name, " counts_cleared"}, m_ci + m_cb + m_cc, 0);
    i = 0; cyc = 0;
    while (i < nb) begin
      @(negedge clk);
      if (abort_at == i) begin
        reset_n = 1'b0;
        #1;
        check_value({name, " rst_ready"}, m_ready, 0);
        check_value({name, " rst_busy"}, m_busy, 0);
        check_value({name, " rst_done"}, m_done, 0);
        check_value({name, " rst_counts"}, m_ci + m_cb + m_cc, 0);
        byte_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      case (gap_mode)
        1:       byte_valid = (cyc % 3) != 2;
        2:       byte_valid = ($urandom_range(3) != 0);
        default: byte_valid = 1'b1;
      endcase
      byte_in = data[i];
      if (poke_start && i == 1) begin
        pat5 = ~pat5; pat8 = ~pat8;
        set_start(1'b1);
      end
      fire = byte_valid && m_ready;
      @(posedge clk); #1;
      set_start(1'b0);
      if (fire) i++;
      cyc++;
      if (cyc > 4 * nb + 20) begin
        check_value({name, " transfer_timeout"}, cyc, 0);
        break;
      end
    end
    byte_valid = 1'b0;
    check_value({name, " ready_drop_on_last"}, m_ready, 0);
    check_value({name, " done_in_drain"}, m_done, 0);
    @(posedge clk); #1;
    check_value({name, " done"}, m_done, 1);
    check_value({name, " busy_clear"}, m_busy, 0);
    check_value({name, " cnt_inbyte"}, m_ci, ei);
    check_value({name, " cnt_bytes"}, m_cb, eb);
    check_value({name, " cnt_cross"}, m_cc, ec);
    repeat (3) @(posedge clk);
    #1;
    check_value({name, " cnt_cross_hold"}, m_cc, ec);
    check_value({name, " done_hold"}, m_done, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_value("reset ready", m_ready, 0);
    check_value("reset busy", m_busy, 0);
    check_value("reset done", m_done, 0);
    check_value("reset counts", m_ci + m_cb + m_cc, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed scenarios: the hard numbers pin the model as well as the DUT.
    for (int k = 0; k < 256; k++) data[k] = 8'h00;
    run("zeros", 0, 5, 32, 0, 65535, 0, 1'b0, -1);
    check_value("zeros literal inbyte", m_ci, 128);
    check_value("zeros literal cross", m_cc, 252);

    for (int k = 0; k < 256; k++) data[k] = 8'h55;
    run("alt_gaps", 0, 5, 32, 5'b10101, 65535, 1, 1'b0, -1);
    check_value("alt literal cross", m_cc, 126);

    data[0] = 8'h0F; data[1] = 8'hF0;
    run("boundary", 1, 5, 2, 5'b11111, 65535, 0, 1'b0, -1);
    check_value("boundary literal cross", m_cc, 4);

    for (int k = 0; k < 4; k++) data[k] = 8'hA5;
    run("w8_poke", 2, 8, 4, 8'hA5, 65535, 0, 1'b1, -1);
    check_value("w8 literal inbyte", m_ci, 4);

    for (int k = 0; k < 256; k++) data[k] = 8'h00;
    run("saturate", 3, 5, 32, 0, 15, 0, 1'b0, -1);
    check_value("saturate literal cross", m_cc, 15);

    run("reset_mid", 0, 5, 32, 0, 65535, 0, 1'b0, 10);
    run("after_reset", 0, 5, 32, 0, 65535, 0, 1'b0, -1);

    // Randomized runs, low-entropy bytes to keep match counts interesting.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 32; k++) data[k] = 8'($urandom) & 8'($urandom);
      run("rand_def", 0, 5, 32, int'($urandom_range(31)), 65535, 2, 1'b0, -1);
    end
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++)
        data[k] = ($urandom_range(1) == 1) ? 8'h3C : 8'($urandom);
      run("rand_w8", 2, 8, 4, 8'h3C, 65535, 2, 1'b0, -1);
    end
    for (int r = 0; r < 3; r++) begin
      data[0] = 8'($urandom); data[1] = 8'($urandom);
      run("rand_two", 1, 5, 2, int'($urandom_range(31)), 65535, 2, 1'b0, -1);
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 32; k++) data[k] = 8'($urandom) | 8'($urandom);
      run("rand_sat", 3, 5, 32, 5'b11111, 15, 2, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pattern_count_engine.md
Name: pattern_count_engine

Overview:
Hardware pattern-search engine for the program-3 workload. It accepts a string of NUM_BYTES bytes over a valid/ready byte stream, most-significant byte first, and searches it for a PAT_W-bit pattern. It produces three counts: matches inside a byte, bytes holding at least one match, and matches anywhere in the bit stream including across byte boundaries. It sits beside topLevel's data memory path and is parametrised in pattern width, string length and count width.

Parameters:
PAT_W, 5, pattern width in bits; legal range 1..8.
NUM_BYTES, 32, bytes per search; legal range 1..256.
CNT_W, 16, width of each count output; counts saturate at 2^CNT_W-1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; sampled only in IDLE or DONE.
pat  in  PAT_W  pattern; latched on an accepted start.
byte_in  in  8  string byte; bit 7 is the earliest bit of the stream.
byte_valid  in  1  byte_in is valid.
byte_ready  out  1  engine accepts a byte; a byte transfers when byte_valid and byte_ready are both high.
busy  out  1  high from start acceptance until done rises.
done  out  1  level signal; high in DONE until the next accepted start.
cnt_inbyte  out  CNT_W  matches that do not cross a byte boundary.
cnt_bytes  out  CNT_W  bytes containing at least one in-byte match.
cnt_cross  out  CNT_W  matches over the whole stream, crossing allowed.

Behaviour:
- Reset (reset=0, applied at any time, including mid-run): state goes to IDLE; byte_ready=0, busy=0, done=0, all counts=0, history cleared. No partial result survives a reset.
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE with start=1: latch pat, clear the counts, the byte index and the history-valid flag; go to RUN; busy=1, done=0.
- start while in RUN or DRAIN is ignored.
- RUN: byte_ready=1. On each transfer, the index increments. The transfer of byte NUM_BYTES-1 moves the FSM to DRAIN, and byte_ready drops in the same cycle.
- DRAIN: lasts one cycle while the pipeline flushes. Then the FSM goes to DONE with busy=0 and done=1.
- byte_valid is ignored outside RUN, where byte_ready=0. Gaps in byte_valid stall the engine with no effect on results.
- Pipeline:
  - Stage 1 registers three per-byte values: the in-byte popcount (0..9-PAT_W), an any-match bit, and the cross popcount (0..8).
  - Stage 2 adds them into the accumulators.
  - The final counts are valid and done=1 two clocks after the edge that accepts the last byte.
- In-byte windows: byte[k+PAT_W-1:k] for k=0..8-PAT_W, compared with pat.
- Cross windows:
  - A PAT_W-1 bit history of the previous bytes is concatenated with the current byte.
  - There are 8 candidate windows, each ending at one bit of the current byte.
  - For the first byte only the 9-PAT_W fully internal windows count; a history-valid flag gates the rest.
  - Total windows examined = 8*NUM_BYTES-PAT_W+1.
- PAT_W=8: in-byte matching reduces to equality; cross matching still examines 8 windows per byte after the first.
- PAT_W=1: every bit position is a window.
- Accumulators saturate at all-ones and never wrap.
- Count outputs stay stable in DONE until the next start clears them.

Decomposition:
- Shared package pattern_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - a saturating-add function;
  - the constant MAX_WIN_PER_BYTE=8.
- One natural sub-module, byte_window_matcher: combinational, inputs pat, history, byte and history-valid; outputs the in-byte popcount, the any-match bit and the cross popcount.
- The top level holds the FSM, the history register, the pipeline stage and the accumulators.

Test Plan:
1. Defaults; pat=5'b00000; 32 bytes of 0x00 presented back-to-back -> cnt_inbyte=128, cnt_bytes=32, cnt_cross=252; done=1 two clocks after the last transfer.
2. Defaults; pat=5'b10101; 32 bytes of 0x55; byte_valid low on every third cycle -> cnt_inbyte=64, cnt_bytes=32, cnt_cross=126, identical to the no-gap run.
3. NUM_BYTES=2; pat=5'b11111; bytes 0x0F then 0xF0 -> cnt_inbyte=0, cnt_bytes=0, cnt_cross=4 (boundary-only matches).
4. PAT_W=8, NUM_BYTES=4; pat=8'hA5; four bytes of 0xA5 -> cnt_inbyte=4, cnt_bytes=4, cnt_cross=4. Also: a start pulse during RUN is ignored with no change to the result.
5. CNT_W=4 with the scenario-1 stimulus -> all three counts=15 (saturated, no wrap).
6. Reset:
   - Defaults; drive reset low after 10 bytes -> same cycle: byte_ready=0, busy=0, done=0, counts=0.
   - Release reset, then rerun scenario 1 -> 128/32/252.
